// File: rtl/posit_round_pack.sv
// Two-stage round-to-nearest-even and pack stage for the posit square-root result.
// Stage 1 assembles and left-justifies the posit bit string; stage 2 rounds, saturates and packs.
package posit_pkg;
  typedef enum logic [1:0] {
    POSIT32 = 2'd0,
    POSIT16 = 2'd1,
    POSIT8  = 2'd2,
    POSIT64 = 2'd3
  } posit_format_e;

  function automatic int unsigned posit_width(input posit_format_e f);
    case (f)
      POSIT16: return 16;
      POSIT8:  return 8;
      POSIT64: return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int unsigned exp_bits(input posit_format_e f);
    case (f)
      POSIT16: return 1;
      POSIT8:  return 1;
      POSIT64: return 3;
      default: return 2;
    endcase
  endfunction
endpackage

module posit_round_pack
  import posit_pkg::*;
#(
  parameter posit_format_e pFormat = posit_format_e'(0)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic                                  nar_i,
  input  logic                                  zero_i,
  input  logic                                  sign_exp_i,
  input  logic [$clog2(posit_width(pFormat))+4:0] regime_i,
  input  logic [exp_bits(pFormat)-1:0]          exp_i,
  input  logic [2*posit_width(pFormat)-1:0]     mant_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [posit_width(pFormat)-1:0]       result_o,
  output logic                                  inexact_o
);
  localparam int unsigned N  = posit_width(pFormat);
  localparam int unsigned ES = exp_bits(pFormat);
  localparam int unsigned RS = $clog2(N);
  localparam int unsigned RW = RS + 5;
  localparam int unsigned W  = 3 * N + ES;
  localparam int unsigned TW = 2 * N + ES;

  typedef struct packed {
    logic [N-2:0] kept;
    logic         guard;
    logic         sticky;
    logic         sat;
    logic         sign_exp;
    logic         nar;
    logic         zero;
  } s1_payload_t;

  logic        s1_valid, s2_valid;
  s1_payload_t s1_q;

  logic        advance_c, s1_en_c, in_fire_c;
  logic        sat_c;
  logic [RW-1:0] r_eff_c;
  logic [W-1:0]  fill_c, tail_c, str_c;
  s1_payload_t   s1_d_c;
  logic          hidden_unused_c;

  // Handshake: s1 may also refill into a bubble while s2 is stalled.
  assign advance_c  = !s2_valid || out_ready_i;
  assign s1_en_c    = advance_c || !s1_valid;
  assign in_ready_o = s1_en_c;
  assign in_fire_c  = in_valid_i && in_ready_o;
  assign out_valid_o = s2_valid;

  // The hidden bit is implied by the terminator position and never shifted in.
  assign hidden_unused_c = mant_i[2*N-1];

  // Stage 1: regime run, terminator, exponent and fraction, left-justified.
  always_comb begin
    sat_c   = (regime_i >= RW'(N - 1));
    r_eff_c = (regime_i == '0) ? RW'(1) : regime_i;
    if (sat_c) r_eff_c = RW'(1);
    fill_c  = ~({W{1'b1}} >> r_eff_c) & {W{~sign_exp_i}};
    tail_c  = {sign_exp_i, exp_i, mant_i[2*N-2:0], {(W-TW){1'b0}}} >> r_eff_c;
    str_c   = fill_c | tail_c;

    s1_d_c          = '0;
    s1_d_c.kept     = str_c[W-1 -: N-1];
    s1_d_c.guard    = str_c[W-N];
    s1_d_c.sticky   = |str_c[W-N-1:0];
    s1_d_c.sat      = sat_c;
    s1_d_c.sign_exp = sign_exp_i;
    s1_d_c.nar      = nar_i;
    s1_d_c.zero     = zero_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (s1_en_c)   s1_valid <= in_valid_i;
      if (in_fire_c) s1_q     <= s1_d_c;
    end
  end

  logic         rnd_c;
  logic [N-2:0] sum_c;
  logic [N-1:0] res_c;
  logic         inx_c;

  // Stage 2: specials in priority order, otherwise round-to-nearest-even.
  always_comb begin
    res_c = '0;
    inx_c = 1'b0;
    rnd_c = s1_q.guard & (s1_q.sticky | s1_q.kept[0]);
    sum_c = (N-1)'(s1_q.kept + (N-1)'(rnd_c));
    if (s1_q.nar) begin
      res_c = {1'b1, {(N-1){1'b0}}};
    end else if (s1_q.zero) begin
      res_c = '0;
    end else if (s1_q.sat) begin
      res_c = s1_q.sign_exp ? N'(1) : {1'b0, {(N-1){1'b1}}};
    end else begin
      res_c = {1'b0, sum_c};
      if (sum_c == '0) res_c = N'(1);
      inx_c = s1_q.guard | s1_q.sticky;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid  <= 1'b0;
      result_o  <= '0;
      inexact_o <= 1'b0;
    end else if (advance_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result_o  <= res_c;
        inexact_o <= inx_c;
      end
    end
  end
endmodule
